pipeline_sequencer: RTL

Issue-stage controller for the five-stage core. Sits beside the ID-stage decoder and decides, each cycle, whether the instruction in ID issues, stalls, or is split into micro-ops. It drives the pipeline freeze/bubble/flush controls, sequences the two-cycle swap (SWP) instruction, and detects data hazards against the EXE and MEM stages.

---
 rtl/core_pkg.sv | 20 ++
 rtl/hazard_detect.sv | 47 ++++
 rtl/pipeline_sequencer.sv | 104 ++++++++++
 3 files changed

// File: rtl/core_pkg.sv
// Shared core definitions: opcodes, exec_cmd codes, swap select encodings and
// the issue-sequencer state type.
package core_pkg;

  localparam logic [5:0] OP_SWP = 6'b111111;

  localparam logic [3:0] CMD_NONE       = 4'b0000;
  localparam logic [3:0] CMD_SWP_FIRST  = 4'b1100;
  localparam logic [3:0] CMD_SWP_SECOND = 4'b1101;

  localparam logic [1:0] SWP_SEL_NONE   = 2'b00;
  localparam logic [1:0] SWP_SEL_FIRST  = 2'b01;
  localparam logic [1:0] SWP_SEL_SECOND = 2'b10;

  typedef enum logic [0:0] {
    SEQ_RUN  = 1'b0,
    SEQ_SWP2 = 1'b1
  } seq_state_e;

endpackage

// File: rtl/hazard_detect.sv
// Combinational RAW hazard check of the ID sources against EXE/MEM destinations.
// With SEQ_FORWARDING_EN defined only the load-use case (EXE load) qualifies.
module hazard_detect #(
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] src1,
  input  logic [REG_AW-1:0] src2,
  input  logic              single_src,
  input  logic              mem_w_en_id,
  input  logic [REG_AW-1:0] exe_dest,
  input  logic              exe_wb_en,
  input  logic              exe_mem_r_en,
  input  logic [REG_AW-1:0] mem_dest,
  input  logic              mem_wb_en,
  output logic              hazard
);

  logic exe_qual;
  logic mem_qual;
  logic use_src2;
  logic hit1;
  logic hit2;

`ifdef SEQ_FORWARDING_EN
  // Forwarding covers everything except a load result still in EXE.
  assign exe_qual = exe_mem_r_en;
  assign mem_qual = 1'b0;
  logic unused_ok;
  assign unused_ok = exe_wb_en ^ mem_wb_en ^ (^mem_dest);
`else
  assign exe_qual = exe_wb_en;
  assign mem_qual = mem_wb_en;
  logic unused_ok;
  assign unused_ok = exe_mem_r_en;
`endif

  // Stores read src2 as the data operand even when the decoder flags single_src.
  assign use_src2 = !single_src || mem_w_en_id;

  assign hit1 = (src1 != '0) &&
                ((exe_qual && (src1 == exe_dest)) || (mem_qual && (src1 == mem_dest)));
  assign hit2 = (src2 != '0) &&
                ((exe_qual && (src2 == exe_dest)) || (mem_qual && (src2 == mem_dest)));

  assign hazard = hit1 || (use_src2 && hit2);

endmodule

// File: rtl/pipeline_sequencer.sv
// ID-stage issue controller: hazard stalls, branch flush and two-cycle SWP
// sequencing. Build option SEQ_FORWARDING_EN selects load-use-only hazards.
module pipeline_sequencer
  import core_pkg::*;
#(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [5:0]        opcode,
  input  logic [REG_AW-1:0] src1,
  input  logic [REG_AW-1:0] src2,
  input  logic              single_src,
  input  logic              mem_w_en_id,
  input  logic [REG_AW-1:0] exe_dest,
  input  logic              exe_wb_en,
  input  logic              exe_mem_r_en,
  input  logic [REG_AW-1:0] mem_dest,
  input  logic              mem_wb_en,
  input  logic              branch_taken,
  output logic              freeze,
  output logic              bubble,
  output logic              flush,
  output logic [1:0]        swp_sel,
  output logic              uop_valid,
  output logic [3:0]        uop_cmd,
  output logic [CNT_W-1:0]  stall_cnt,
  output seq_state_e        dbg_state_o
);

  seq_state_e       state_q, state_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic             hazard;
  logic             stall_inc;

  hazard_detect #(.REG_AW(REG_AW)) u_hazard (
    .src1         (src1),
    .src2         (src2),
    .single_src   (single_src),
    .mem_w_en_id  (mem_w_en_id),
    .exe_dest     (exe_dest),
    .exe_wb_en    (exe_wb_en),
    .exe_mem_r_en (exe_mem_r_en),
    .mem_dest     (mem_dest),
    .mem_wb_en    (mem_wb_en),
    .hazard       (hazard)
  );

  always_comb begin
    state_d   = state_q;
    freeze    = 1'b0;
    bubble    = 1'b0;
    flush     = 1'b0;
    swp_sel   = SWP_SEL_NONE;
    uop_valid = 1'b0;
    uop_cmd   = CMD_NONE;
    stall_inc = 1'b0;
    if (rst) begin
      state_d = SEQ_RUN;
    end else if (branch_taken) begin
      flush   = 1'b1;
      bubble  = 1'b1;
      state_d = SEQ_RUN;
    end else if (state_q == SEQ_SWP2) begin
      // The first micro-op already cleared hazards, so no recheck here.
      swp_sel   = SWP_SEL_SECOND;
      uop_valid = 1'b1;
      uop_cmd   = CMD_SWP_SECOND;
      state_d   = SEQ_RUN;
    end else if (hazard) begin
      freeze    = 1'b1;
      bubble    = 1'b1;
      stall_inc = 1'b1;
    end else if (opcode == OP_SWP) begin
      swp_sel   = SWP_SEL_FIRST;
      uop_valid = 1'b1;
      uop_cmd   = CMD_SWP_FIRST;
      freeze    = 1'b1;
      state_d   = SEQ_SWP2;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall_inc && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= SEQ_RUN;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt   = stall_cnt_q;
  assign dbg_state_o = state_q;

endmodule
